// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding and fetch constants.
package instruction_fetch_pkg;

   // FSM state encoding, kept as plain constants so legacy code can compare raw bits.
   typedef logic [1:0] fsm_state_t;

   localparam fsm_state_t ST_IDLE  = 2'd0;
   localparam fsm_state_t ST_RUN   = 2'd1;
   localparam fsm_state_t ST_FAULT = 2'd2;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES      = 32'd4;

   // A redirect target is only legal when it is word aligned.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of control, instruction-memory and IF/ID signals around the fetch stage.
interface instruction_fetch_if;

   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fault;
   logic [31:0] fetch_count;

   // Fetch unit side.
   modport master (
      input  stall, branch_taken, branch_target, jump, jump_target, imem_data,
      output imem_addr, if_id_instr, if_id_pc4, if_id_valid, fault, fetch_count
   );

   // Pipeline control / memory side.
   modport slave (
      output stall, branch_taken, branch_target, jump, jump_target, imem_data,
      input  imem_addr, if_id_instr, if_id_pc4, if_id_valid, fault, fetch_count
   );

endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter with next-PC selection and redirect alignment check.
module pc_reg
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        active,
   input  logic        stall,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] pc,
   output logic        redirect_ok,
   output logic        redirect_bad,
   output logic        advance
);

   logic [31:0] pc_q, pc_d;
   logic        redirect;
   logic [31:0] target;
   logic        target_bad;

   // Resolve the winning redirect (jump beats branch) and pick the next PC.
   always_comb begin
      redirect     = jump | branch_taken;
      target       = jump ? jump_target : branch_target;
      target_bad   = is_misaligned(target);
      redirect_ok  = active & redirect & ~target_bad;
      redirect_bad = active & redirect & target_bad;
      advance      = active & ~redirect & ~stall;
      pc_d         = pc_q;
      if (redirect_ok) begin
         pc_d = target;
      end else if (advance) begin
         pc_d = pc_q + INSTR_BYTES;
      end
   end

   // PC register; a misaligned redirect leaves it untouched.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing, IF/ID pipeline register, fetch counter and FSM.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   instruction_fetch_if.master bus
);

   fsm_state_t  state;
   logic [31:0] pc;
   logic        redirect_ok;
   logic        redirect_bad;
   logic        advance;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        fault;
   logic [31:0] fetch_count;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .active        (state == ST_RUN),
      .stall         (bus.stall),
      .jump          (bus.jump),
      .jump_target   (bus.jump_target),
      .branch_taken  (bus.branch_taken),
      .branch_target (bus.branch_target),
      .pc            (pc),
      .redirect_ok   (redirect_ok),
      .redirect_bad  (redirect_bad),
      .advance       (advance)
   );

   // FSM: one idle cycle after reset, then run until a misaligned redirect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  state <= ST_RUN;
            ST_RUN:   if (redirect_bad) state <= ST_FAULT;
            ST_FAULT: state <= ST_FAULT;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // IF/ID register and fetch counter; any redirect inserts a bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if_id_instr <= '0;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
         fetch_count <= '0;
      end else if (advance) begin
         if_id_instr <= bus.imem_data;
         if_id_pc4   <= pc + INSTR_BYTES;
         if_id_valid <= 1'b1;
         fetch_count <= fetch_count + 32'd1;
      end else if (redirect_ok || redirect_bad) begin
         if_id_valid <= 1'b0;
      end
   end

   // Sticky fault flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fault <= 1'b0;
      end else if (redirect_bad) begin
         fault <= 1'b1;
      end
   end

   assign bus.imem_addr   = pc;
   assign bus.if_id_instr = if_id_instr;
   assign bus.if_id_pc4   = if_id_pc4;
   assign bus.if_id_valid = if_id_valid;
   assign bus.fault       = fault;
   assign bus.fetch_count = fetch_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: stimulus queues expectations, monitor checks them.
module tb_instruction_fetch;

   typedef struct {
      int          due;
      string       name;
      logic [31:0] addr;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        fault;
      logic [31:0] cnt;
   } exp_t;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } exp2_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t  q[$];
   exp2_t q2[$];

   instruction_fetch_if bus ();
   instruction_fetch_if bus2 ();

   // Memory returns the word equal to its address.
   assign bus.imem_data  = bus.imem_addr;
   assign bus2.imem_data = bus2.imem_addr;
   assign bus2.stall         = 1'b0;
   assign bus2.branch_taken  = 1'b0;
   assign bus2.branch_target = 32'h0;
   assign bus2.jump          = 1'b0;
   assign bus2.jump_target   = 32'h0;

   instruction_fetch dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   instruction_fetch #(
      .RESET_PC (32'hFFFF_FFF8)
   ) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Monitor: compare every expectation that has fallen due.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
         exp_t e;
         e = q.pop_front();
         chk({e.name, ".imem_addr"}, bus.imem_addr, e.addr);
         chk({e.name, ".if_id_instr"}, bus.if_id_instr, e.instr);
         chk({e.name, ".if_id_pc4"}, bus.if_id_pc4, e.pc4);
         chk({e.name, ".if_id_valid"}, {31'b0, bus.if_id_valid}, {31'b0, e.valid});
         chk({e.name, ".fault"}, {31'b0, bus.fault}, {31'b0, e.fault});
         chk({e.name, ".fetch_count"}, bus.fetch_count, e.cnt);
      end
      while (q2.size() > 0 && q2[0].due <= cyc) begin
         exp2_t e2;
         e2 = q2.pop_front();
         chk("wrap_pc.imem_addr", bus2.imem_addr, e2.addr);
      end
   end

   // Drive one cycle of inputs and queue the state expected after the next edge.
   task automatic step(input string name, input logic rn, input logic st,
                       input logic br, input logic [31:0] bt,
                       input logic j, input logic [31:0] jt,
                       input logic [31:0] e_addr, input logic [31:0] e_instr,
                       input logic [31:0] e_pc4, input logic e_valid,
                       input logic e_fault, input logic [31:0] e_cnt);
      exp_t e;
      rst_n             = rn;
      bus.stall         = st;
      bus.branch_taken  = br;
      bus.branch_target = bt;
      bus.jump          = j;
      bus.jump_target   = jt;
      e.due   = cyc + 1;
      e.name  = name;
      e.addr  = e_addr;
      e.instr = e_instr;
      e.pc4   = e_pc4;
      e.valid = e_valid;
      e.fault = e_fault;
      e.cnt   = e_cnt;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
      bus.jump          = 1'b0;
      bus.jump_target   = 32'h0;

      // Second instance: reset PC near the top of the address space.
      q2.push_back('{due: 1, addr: 32'hFFFF_FFF8});
      q2.push_back('{due: 2, addr: 32'hFFFF_FFF8});
      q2.push_back('{due: 3, addr: 32'hFFFF_FFFC});
      q2.push_back('{due: 4, addr: 32'h0000_0000});

      //   name            rn st br bt        j  jt        addr      instr     pc4       v  f  cnt
      step("reset",        0, 0, 0, 32'h0,   0, 32'h0,   32'h0,    32'h0,    32'h0,    0, 0, 0);
      step("idle",         1, 0, 0, 32'h0,   0, 32'h0,   32'h0,    32'h0,    32'h0,    0, 0, 0);
      step("fetch0",       1, 0, 0, 32'h0,   0, 32'h0,   32'h4,    32'h0,    32'h4,    1, 0, 1);
      step("fetch4",       1, 0, 0, 32'h0,   0, 32'h0,   32'h8,    32'h4,    32'h8,    1, 0, 2);
      step("fetch8",       1, 0, 0, 32'h0,   0, 32'h0,   32'hC,    32'h8,    32'hC,    1, 0, 3);
      step("fetch12",      1, 0, 0, 32'h0,   0, 32'h0,   32'h10,   32'hC,    32'h10,   1, 0, 4);
      for (int i = 0; i < 3; i++) begin
         step("stall",     1, 1, 0, 32'h0,   0, 32'h0,   32'h10,   32'hC,    32'h10,   1, 0, 4);
      end
      step("fetch16",      1, 0, 0, 32'h0,   0, 32'h0,   32'h14,   32'h10,   32'h14,   1, 0, 5);
      step("fetch20",      1, 0, 0, 32'h0,   0, 32'h0,   32'h18,   32'h14,   32'h18,   1, 0, 6);
      step("branch40",     1, 0, 1, 32'h40,  0, 32'h0,   32'h40,   32'h14,   32'h18,   0, 0, 6);
      step("fetch40",      1, 0, 0, 32'h0,   0, 32'h0,   32'h44,   32'h40,   32'h44,   1, 0, 7);
      step("jump_wins",    1, 1, 1, 32'h40,  1, 32'h80,  32'h80,   32'h40,   32'h44,   0, 0, 7);
      step("fetch80",      1, 0, 0, 32'h0,   0, 32'h0,   32'h84,   32'h80,   32'h84,   1, 0, 8);
      step("jump_bad_br",  1, 0, 1, 32'h43,  1, 32'h100, 32'h100,  32'h80,   32'h84,   0, 0, 8);
      step("fetch100",     1, 0, 0, 32'h0,   0, 32'h0,   32'h104,  32'h100,  32'h104,  1, 0, 9);
      step("branch_mis",   1, 0, 1, 32'h42,  0, 32'h0,   32'h104,  32'h100,  32'h104,  0, 1, 9);
      for (int i = 0; i < 10; i++) begin
         logic [3:0] b;
         b = i[3:0];
         step("fault_hold", 1, 0, b[0], 32'h40, b[1], 32'h200,
              32'h104, 32'h100, 32'h104, 0, 1, 9);
      end
      step("rst_in_fault", 0, 1, 1, 32'h40,  1, 32'h80,  32'h0,    32'h0,    32'h0,    0, 0, 0);
      step("idle2",        1, 0, 0, 32'h0,   0, 32'h0,   32'h0,    32'h0,    32'h0,    0, 0, 0);
      step("refetch0",     1, 0, 0, 32'h0,   0, 32'h0,   32'h4,    32'h0,    32'h4,    1, 0, 1);
      step("misjump",      1, 0, 0, 32'h0,   1, 32'h81,  32'h4,    32'h0,    32'h4,    0, 1, 1);

      // Let the monitor drain; anything left over is a missed check.
      for (int i = 0; i < 5 && (q.size() > 0 || q2.size() > 0); i++) begin
         @(posedge clk);
      end
      @(negedge clk);
      #1;
      if (q.size() > 0 || q2.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain got=%0d pending want=0 pending", q.size() + q2.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
